// File: rtl/receiver_framer.sv
// receiver_framer: oversampling serial frame receiver with size/data/CRC-8.
// Frame on the line: start(1) size[3:0] data[size*8] crc[7:0] stop(0).
//
// Parameters:
//   SYNC_STAGES  flops in the RX synchroniser (>= 2)
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   RX         serial line, idles low
//   baudrate   clock cycles per bit (0/1 behave as 2), latched at start
//   RXI        high while idle and waiting for a start bit
//   rf         one-cycle pulse: frame received, outputs updated
//   framesize  received byte count
//   framebits  received bytes, byte k at [127-8k:120-8k]
//   crcerr     received CRC differs from computed CRC (valid with rf)
//   ferr       one-cycle pulse: false start or stop bit sampled high
// Build option: define RX_CRC_CHECK_EN to compute and compare the CRC;
// without it the CRC byte is sampled and dropped and crcerr stays 0.
module receiver_framer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RX,
    input  logic [7:0]   baudrate,
    output logic         RXI,
    output logic         rf,
    output logic [3:0]   framesize,
    output logic [127:0] framebits,
    output logic         crcerr,
    output logic         ferr
);

    typedef enum logic [2:0] {
        IDLE, START, SIZE, DATA, CRC, STOP
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sync;
    logic                   srx;
    logic [7:0]             b_q;
    logic [7:0]             b_eff;
    logic [7:0]             cnt;
    logic [6:0]             nbit;
    logic                   tick;
    logic                   stop_wait;
    logic [3:0]             size_sh;
    logic [3:0]             size_nx;
    logic [127:0]           data_sh;
    logic                   frame_done;
    logic                   frame_bad;
    logic                   entering_size;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], RX};
    end

    assign srx   = sync[SYNC_STAGES-1];
    assign b_eff = (baudrate < 8'd2) ? 8'd2 : baudrate;
    assign RXI   = (state == IDLE);

    // The counter is cleared on the detect cycle, so the start bit is
    // sampled B/2 cycles after detection and every later bit B cycles on.
    always_comb begin
        if (state == START) tick = (cnt == {1'b0, b_q[7:1]} - 8'd1);
        else                tick = (cnt == b_q - 8'd1);
    end

    assign size_nx = {size_sh[2:0], srx};

    always_comb begin
        state_nx      = state;
        frame_done    = 1'b0;
        frame_bad     = 1'b0;
        entering_size = 1'b0;
        unique case (state)
            IDLE: if (srx) state_nx = START;
            START: begin
                if (tick) begin
                    if (srx) begin
                        state_nx      = SIZE;
                        entering_size = 1'b1;
                    end else begin
                        state_nx  = IDLE;
                        frame_bad = 1'b1;
                    end
                end
            end
            SIZE: begin
                if (tick && nbit == 7'd3)
                    state_nx = (size_nx == 4'd0) ? CRC : DATA;
            end
            DATA: begin
                if (tick && nbit == {size_sh, 3'b000} - 7'd1)
                    state_nx = CRC;
            end
            CRC: if (tick && nbit == 7'd7) state_nx = STOP;
            STOP: begin
                if (stop_wait) begin
                    if (!srx) state_nx = IDLE;
                end else if (tick) begin
                    if (!srx) begin
                        state_nx   = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q       <= 8'd2;
            cnt       <= '0;
            nbit      <= '0;
            stop_wait <= 1'b0;
            size_sh   <= '0;
            data_sh   <= '0;
            rf        <= 1'b0;
            ferr      <= 1'b0;
            framesize <= '0;
            framebits <= '0;
        end else begin
            rf   <= frame_done;
            ferr <= frame_bad;
            if (state == IDLE || tick) cnt <= '0;
            else                       cnt <= cnt + 8'd1;
            if (state == IDLE && srx) b_q <= b_eff;
            if (state_nx != state) nbit <= '0;
            else if (tick)         nbit <= nbit + 7'd1;
            if (state_nx == IDLE)                 stop_wait <= 1'b0;
            else if (frame_bad && state == STOP) stop_wait <= 1'b1;
            if (entering_size) data_sh <= '0;
            if (state == SIZE && tick) size_sh <= size_nx;
            if (state == DATA && tick) data_sh[7'd127 - nbit] <= srx;
            if (frame_done) begin
                framesize <= size_sh;
                framebits <= data_sh;
            end
        end
    end

`ifdef RX_CRC_CHECK_EN
    logic [7:0] crc_q;
    logic [7:0] crc_nx;
    logic [7:0] crc_rx;
    logic       crcerr_q;

    // CRC-8, poly 0x07, MSB first over size and data bits.
    assign crc_nx = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ srx) ? 8'h07 : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q    <= '0;
            crc_rx   <= '0;
            crcerr_q <= 1'b0;
        end else begin
            if (entering_size) crc_q <= '0;
            else if ((state == SIZE || state == DATA) && tick) crc_q <= crc_nx;
            if (state == CRC && tick) crc_rx <= {crc_rx[6:0], srx};
            if (frame_done) crcerr_q <= (crc_rx != crc_q);
        end
    end

    assign crcerr = crcerr_q;
`else
    assign crcerr = 1'b0;
`endif

endmodule

// File: tb/tb_receiver_framer.sv
// tb_receiver_framer: directed self-checking bench for receiver_framer.
// Each task drives one scenario and checks outputs against hand-computed values.
module tb_receiver_framer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         RX = 1'b0;
    logic [7:0]   baudrate = 8'd4;
    logic         RXI;
    logic         rf;
    logic [3:0]   framesize;
    logic [127:0] framebits;
    logic         crcerr;
    logic         ferr;

    int checks = 0;
    int errors = 0;
    int rf_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;

`ifdef RX_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    receiver_framer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .baudrate(baudrate),
        .RXI(RXI), .rf(rf), .framesize(framesize),
        .framebits(framebits), .crcerr(crcerr), .ferr(ferr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf) rf_cnt++;
        if (ferr) ferr_cnt++;
        if (rf && ferr) both_cnt++;
    end

    task automatic bit_out(input logic v, input int p);
        RX = v;
        repeat (p) @(posedge clk);
        #1;
    endtask

    // Baudrate on the port is scrambled after the first size bit to show
    // that the latched value governs the rest of the frame.
    task automatic send_frame(input int b, input logic [3:0] sz,
                              input logic [127:0] data,
                              input logic [7:0] crc, input logic stopb);
        int p;
        p = (b < 2) ? 2 : b;
        baudrate = 8'(b);
        bit_out(1'b1, p);
        for (int i = 3; i >= 0; i--) begin
            bit_out(sz[i], p);
            baudrate = 8'd77;
        end
        for (int k = 0; k < int'(sz); k++)
            for (int j = 0; j < 8; j++)
                bit_out(data[127 - 8 * k - j], p);
        for (int i = 7; i >= 0; i--) bit_out(crc[i], p);
        bit_out(stopb, p);
        bit_out(1'b0, p + 10);
    endtask

    task automatic clear_counts();
        rf_cnt = 0;
        ferr_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (RXI !== 1'b1) begin errors++; $display("FAIL reset_rxi got %b want 1", RXI); end
        checks++; if (rf !== 1'b0) begin errors++; $display("FAIL reset_rf got %b want 0", rf); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
        checks++; if (crcerr !== 1'b0) begin errors++; $display("FAIL reset_crcerr got %b want 0", crcerr); end
        checks++; if (framesize !== 4'd0) begin errors++; $display("FAIL reset_size got %0d want 0", framesize); end
        checks++; if (framebits !== 128'd0) begin errors++; $display("FAIL reset_bits got %h want 0", framebits); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        clear_counts();
        send_frame(4, 4'd1, {8'hA5, 120'd0}, 8'h67, 1'b0);
        checks++; if (rf_cnt !== 1) begin errors++; $display("FAIL good_rf_count got %0d want 1", rf_cnt); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL good_ferr_count got %0d want 0", ferr_cnt); end
        checks++; if (framesize !== 4'd1) begin errors++; $display("FAIL good_size got %0d want 1", framesize); end
        checks++; if (framebits !== {8'hA5, 120'd0}) begin errors++; $display("FAIL good_bits got %h want a5 then zeros", framebits); end
        checks++; if (crcerr !== 1'b0) begin errors++; $display("FAIL good_crcerr got %b want 0", crcerr); end
        checks++; if (RXI !== 1'b1) begin errors++; $display("FAIL good_rxi got %b want 1", RXI); end
    endtask

    task automatic test_crc_error();
        clear_counts();
        send_frame(4, 4'd1, {8'hA5, 120'd0}, 8'h66, 1'b0);
        checks++; if (rf_cnt !== 1) begin errors++; $display("FAIL crc_rf_count got %0d want 1", rf_cnt); end
        checks++; if (crcerr !== CRC_ON) begin errors++; $display("FAIL crc_crcerr got %b want %b", crcerr, CRC_ON); end
        checks++; if (framebits !== {8'hA5, 120'd0}) begin errors++; $display("FAIL crc_bits got %h want a5 then zeros", framebits); end
    endtask

    task automatic test_false_start();
        clear_counts();
        baudrate = 8'd8;
        bit_out(1'b1, 3);
        bit_out(1'b0, 20);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL fstart_ferr got %0d want 1", ferr_cnt); end
        checks++; if (rf_cnt !== 0) begin errors++; $display("FAIL fstart_rf got %0d want 0", rf_cnt); end
        checks++; if (RXI !== 1'b1) begin errors++; $display("FAIL fstart_rxi got %b want 1", RXI); end
        checks++; if (crcerr !== CRC_ON) begin errors++; $display("FAIL fstart_hold_crcerr got %b want %b", crcerr, CRC_ON); end
    endtask

    task automatic test_empty_frame();
        clear_counts();
        send_frame(4, 4'd0, 128'd0, 8'h00, 1'b0);
        checks++; if (rf_cnt !== 1) begin errors++; $display("FAIL empty_rf got %0d want 1", rf_cnt); end
        checks++; if (framesize !== 4'd0) begin errors++; $display("FAIL empty_size got %0d want 0", framesize); end
        checks++; if (framebits !== 128'd0) begin errors++; $display("FAIL empty_bits got %h want 0", framebits); end
        checks++; if (crcerr !== 1'b0) begin errors++; $display("FAIL empty_crcerr got %b want 0", crcerr); end
    endtask

    task automatic test_min_baud();
        clear_counts();
        send_frame(0, 4'd1, {8'hA5, 120'd0}, 8'h67, 1'b0);
        checks++; if (rf_cnt !== 1) begin errors++; $display("FAIL minbaud_rf got %0d want 1", rf_cnt); end
        checks++; if (framesize !== 4'd1) begin errors++; $display("FAIL minbaud_size got %0d want 1", framesize); end
        checks++; if (framebits !== {8'hA5, 120'd0}) begin errors++; $display("FAIL minbaud_bits got %h want a5 then zeros", framebits); end
        checks++; if (crcerr !== 1'b0) begin errors++; $display("FAIL minbaud_crcerr got %b want 0", crcerr); end
    endtask

    task automatic test_stop_error();
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < 15; k++) d[127 - 8 * k -: 8] = 8'(k);
        clear_counts();
        send_frame(4, 4'd15, d, 8'h00, 1'b1);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL stop_ferr got %0d want 1", ferr_cnt); end
        checks++; if (rf_cnt !== 0) begin errors++; $display("FAIL stop_rf got %0d want 0", rf_cnt); end
        checks++; if (framesize !== 4'd1) begin errors++; $display("FAIL stop_hold_size got %0d want 1", framesize); end
        checks++; if (framebits !== {8'hA5, 120'd0}) begin errors++; $display("FAIL stop_hold_bits got %h want a5 then zeros", framebits); end
        checks++; if (RXI !== 1'b1) begin errors++; $display("FAIL stop_rxi got %b want 1", RXI); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b0;
        b0 = 8'h12;
        clear_counts();
        baudrate = 8'd4;
        bit_out(1'b1, 4);
        for (int i = 3; i >= 0; i--) bit_out(i == 1, 4);
        for (int i = 7; i >= 0; i--) bit_out(b0[i], 4);
        for (int i = 0; i < 4; i++) bit_out(i[0], 4);
        rst_n = 1'b0;
        #2;
        checks++; if (RXI !== 1'b1) begin errors++; $display("FAIL midrst_rxi got %b want 1", RXI); end
        checks++; if (framesize !== 4'd0) begin errors++; $display("FAIL midrst_size got %0d want 0", framesize); end
        checks++; if (framebits !== 128'd0) begin errors++; $display("FAIL midrst_bits got %h want 0", framebits); end
        RX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bit_out(1'b0, 30);
        checks++; if (rf_cnt !== 0) begin errors++; $display("FAIL midrst_rf got %0d want 0", rf_cnt); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL midrst_ferr got %0d want 0", ferr_cnt); end
        send_frame(4, 4'd1, {8'hA5, 120'd0}, 8'h67, 1'b0);
        checks++; if (rf_cnt !== 1) begin errors++; $display("FAIL postrst_rf got %0d want 1", rf_cnt); end
        checks++; if (framesize !== 4'd1) begin errors++; $display("FAIL postrst_size got %0d want 1", framesize); end
        checks++; if (framebits !== {8'hA5, 120'd0}) begin errors++; $display("FAIL postrst_bits got %h want a5 then zeros", framebits); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_false_start();
        test_empty_frame();
        test_min_baud();
        test_stop_error();
        test_reset_mid();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rf_ferr_overlap got %0d want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
